// File: rtl/ex_mem_ovf_stage.sv
// ex_mem_ovf_stage
// EX/MEM pipeline register that turns a trapping signed-arithmetic overflow
// into a precise exception. The faulting instruction is squashed: its valid
// bit and its register/memory enables are cleared. Its EPC and cause are
// recorded. flush/exc_req are then held until the control unit acknowledges
// the exception.
//
// Ports
//   clock, reset                 rising-edge clock, async active-low reset
//   ex_*                         instruction presented by the EX stage
//   mem_stall                    hold the mem_* registers (only while running)
//   exc_ack                      control unit has taken the pending exception
//   mem_*                        registered instruction for the MEM stage
//   flush, exc_req               exception pending (both high in TRAP)
//   epc, cause                   PC and cause of the last overflow trap
//   ovf_count                    saturating count of overflow traps taken
//
// state | meaning
// RUN   | normal operation, EX slot captured unless stalled
// TRAP  | exception pending, waiting for exc_ack
// DRAIN | one cycle discarding the in-flight EX slot

module ex_mem_ovf_stage #(
   parameter int         WIDTH     = 32,
   parameter logic [4:0] CAUSE_OVF = 5'd12,
   parameter int         CNT_W     = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [WIDTH-1:0] ex_aluout,
   input  logic             ex_overflow,
   input  logic             ex_trap_en,
   input  logic [WIDTH-1:0] ex_pc,
   input  logic [4:0]       ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic             ex_memwrite,
   input  logic [WIDTH-1:0] ex_wdata,
   input  logic             mem_stall,
   input  logic             exc_ack,
   output logic             mem_valid,
   output logic [WIDTH-1:0] mem_aluout,
   output logic             mem_overflow,
   output logic [4:0]       mem_rd,
   output logic             mem_regwrite,
   output logic             mem_memread,
   output logic             mem_memwrite,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             flush,
   output logic             exc_req,
   output logic [WIDTH-1:0] epc,
   output logic [4:0]       cause,
   output logic [CNT_W-1:0] ovf_count
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_TRAP  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic               mem_valid_q, mem_valid_d;
   logic [WIDTH-1:0]   mem_aluout_q, mem_aluout_d;
   logic               mem_overflow_q, mem_overflow_d;
   logic [4:0]         mem_rd_q, mem_rd_d;
   logic               mem_regwrite_q, mem_regwrite_d;
   logic               mem_memread_q, mem_memread_d;
   logic               mem_memwrite_q, mem_memwrite_d;
   logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
   logic               exc_req_q, exc_req_d;
   logic [WIDTH-1:0]   epc_q, epc_d;
   logic [4:0]         cause_q, cause_d;
   logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;
   logic               trap;

   assign trap = ex_valid & ex_overflow & ex_trap_en;

   always_comb begin
      state_d        = state_q;
      mem_valid_d    = mem_valid_q;
      mem_aluout_d   = mem_aluout_q;
      mem_overflow_d = mem_overflow_q;
      mem_rd_d       = mem_rd_q;
      mem_regwrite_d = mem_regwrite_q;
      mem_memread_d  = mem_memread_q;
      mem_memwrite_d = mem_memwrite_q;
      mem_wdata_d    = mem_wdata_q;
      epc_d          = epc_q;
      cause_d        = cause_q;
      ovf_count_d    = ovf_count_q;

      case (state_q)
         ST_RUN: begin
            if (!mem_stall) begin
               // Datapath fields are captured even for a squashed
               // instruction so the faulting result is visible for debug.
               mem_aluout_d   = ex_aluout;
               mem_overflow_d = ex_overflow;
               mem_rd_d       = ex_rd;
               mem_wdata_d    = ex_wdata;
               if (trap) begin
                  mem_valid_d    = 1'b0;
                  mem_regwrite_d = 1'b0;
                  mem_memread_d  = 1'b0;
                  mem_memwrite_d = 1'b0;
                  epc_d          = ex_pc;
                  cause_d        = CAUSE_OVF;
                  if (!(&ovf_count_q))
                     ovf_count_d = ovf_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                  state_d        = ST_TRAP;
               end else begin
                  mem_valid_d    = ex_valid;
                  mem_regwrite_d = ex_regwrite;
                  mem_memread_d  = ex_memread;
                  mem_memwrite_d = ex_memwrite;
               end
            end
         end
         ST_TRAP: begin
            mem_valid_d    = 1'b0;
            mem_regwrite_d = 1'b0;
            mem_memread_d  = 1'b0;
            mem_memwrite_d = 1'b0;
            if (exc_ack)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            mem_valid_d    = 1'b0;
            mem_regwrite_d = 1'b0;
            mem_memread_d  = 1'b0;
            mem_memwrite_d = 1'b0;
            state_d        = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Own flop for the pending request so flush/exc_req never see a
      // decode glitch while the state bits change.
      exc_req_d = (state_d == ST_TRAP);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_RUN;
         mem_valid_q    <= 1'b0;
         mem_aluout_q   <= '0;
         mem_overflow_q <= 1'b0;
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         mem_memread_q  <= 1'b0;
         mem_memwrite_q <= 1'b0;
         mem_wdata_q    <= '0;
         exc_req_q      <= 1'b0;
         epc_q          <= '0;
         cause_q        <= '0;
         ovf_count_q    <= '0;
      end else begin
         state_q        <= state_d;
         mem_valid_q    <= mem_valid_d;
         mem_aluout_q   <= mem_aluout_d;
         mem_overflow_q <= mem_overflow_d;
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         mem_memread_q  <= mem_memread_d;
         mem_memwrite_q <= mem_memwrite_d;
         mem_wdata_q    <= mem_wdata_d;
         exc_req_q      <= exc_req_d;
         epc_q          <= epc_d;
         cause_q        <= cause_d;
         ovf_count_q    <= ovf_count_d;
      end
   end

   assign mem_valid    = mem_valid_q;
   assign mem_aluout   = mem_aluout_q;
   assign mem_overflow = mem_overflow_q;
   assign mem_rd       = mem_rd_q;
   assign mem_regwrite = mem_regwrite_q;
   assign mem_memread  = mem_memread_q;
   assign mem_memwrite = mem_memwrite_q;
   assign mem_wdata    = mem_wdata_q;
   assign exc_req      = exc_req_q;
   assign flush        = exc_req_q;
   assign epc          = epc_q;
   assign cause        = cause_q;
   assign ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_ex_mem_ovf_stage.sv
module tb_ex_mem_ovf_stage;

   logic        clock;
   logic        reset;
   logic        ex_valid;
   logic [31:0] ex_aluout;
   logic        ex_overflow;
   logic        ex_trap_en;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rd;
   logic        ex_regwrite;
   logic        ex_memread;
   logic        ex_memwrite;
   logic [31:0] ex_wdata;
   logic        mem_stall;
   logic        exc_ack;

   logic        mem_valid, mem_overflow, mem_regwrite, mem_memread, mem_memwrite;
   logic [31:0] mem_aluout, mem_wdata, epc;
   logic [4:0]  mem_rd, cause;
   logic        flush, exc_req;
   logic [15:0] ovf_count;

   logic        s_mem_valid, s_mem_overflow, s_mem_regwrite, s_mem_memread, s_mem_memwrite;
   logic [31:0] s_mem_aluout, s_mem_wdata, s_epc;
   logic [4:0]  s_mem_rd, s_cause;
   logic        s_flush, s_exc_req;
   logic [1:0]  s_ovf_count;

   int checks = 0;
   int errors = 0;

   ex_mem_ovf_stage dut (
      .clock(clock), .reset(reset),
      .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_overflow(ex_overflow),
      .ex_trap_en(ex_trap_en), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_wdata(ex_wdata), .mem_stall(mem_stall), .exc_ack(exc_ack),
      .mem_valid(mem_valid), .mem_aluout(mem_aluout), .mem_overflow(mem_overflow),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
      .mem_memwrite(mem_memwrite), .mem_wdata(mem_wdata), .flush(flush),
      .exc_req(exc_req), .epc(epc), .cause(cause), .ovf_count(ovf_count)
   );

   ex_mem_ovf_stage #(.CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset),
      .ex_valid(ex_valid), .ex_aluout(ex_aluout), .ex_overflow(ex_overflow),
      .ex_trap_en(ex_trap_en), .ex_pc(ex_pc), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_wdata(ex_wdata), .mem_stall(mem_stall), .exc_ack(exc_ack),
      .mem_valid(s_mem_valid), .mem_aluout(s_mem_aluout), .mem_overflow(s_mem_overflow),
      .mem_rd(s_mem_rd), .mem_regwrite(s_mem_regwrite), .mem_memread(s_mem_memread),
      .mem_memwrite(s_mem_memwrite), .mem_wdata(s_mem_wdata), .flush(s_flush),
      .exc_req(s_exc_req), .epc(s_epc), .cause(s_cause), .ovf_count(s_ovf_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_ex();
      ex_valid    = 1'b0;
      ex_aluout   = '0;
      ex_overflow = 1'b0;
      ex_trap_en  = 1'b0;
      ex_pc       = '0;
      ex_rd       = '0;
      ex_regwrite = 1'b0;
      ex_memread  = 1'b0;
      ex_memwrite = 1'b0;
      ex_wdata    = '0;
   endtask

   initial begin
      reset     = 1'b0;
      mem_stall = 1'b0;
      exc_ack   = 1'b0;
      clear_ex();

      // 1. reset with random inputs
      for (int i = 0; i < 4; i++) begin
         ex_valid    = 1'b1;
         ex_aluout   = $urandom;
         ex_overflow = 1'b1;
         ex_trap_en  = 1'b1;
         ex_pc       = $urandom;
         ex_rd       = 5'($urandom);
         ex_regwrite = 1'b1;
         ex_memread  = 1'b1;
         ex_memwrite = 1'b1;
         ex_wdata    = $urandom;
         step();
      end
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_mem_aluout", 64'(mem_aluout), 64'd0);
      chk("rst_mem_ctl", 64'({mem_overflow, mem_regwrite, mem_memread, mem_memwrite}), 64'd0);
      chk("rst_mem_rd_wdata", 64'({mem_rd, mem_wdata}), 64'd0);
      chk("rst_exc", 64'({flush, exc_req}), 64'd0);
      chk("rst_epc_cause", 64'({epc, cause}), 64'd0);
      chk("rst_ovf_count", 64'(ovf_count), 64'd0);

      clear_ex();
      reset = 1'b1;
      step();
      chk("idle_mem_valid", 64'(mem_valid), 64'd0);
      chk("idle_flush", 64'(flush), 64'd0);

      // 2. pass-through
      ex_valid = 1'b1; ex_aluout = 32'h0000_0005; ex_rd = 5'd8; ex_regwrite = 1'b1;
      ex_wdata = 32'hCAFE_0001;
      step();
      chk("pt_mem_valid", 64'(mem_valid), 64'd1);
      chk("pt_mem_aluout", 64'(mem_aluout), 64'd5);
      chk("pt_mem_rd", 64'(mem_rd), 64'd8);
      chk("pt_mem_regwrite", 64'(mem_regwrite), 64'd1);
      chk("pt_mem_wdata", 64'(mem_wdata), 64'hCAFE_0001);
      chk("pt_exc_req", 64'(exc_req), 64'd0);

      // 3. signed trap
      ex_overflow = 1'b1; ex_trap_en = 1'b1; ex_pc = 32'h0040_0010;
      ex_aluout = 32'h7FFF_FFF0; exc_ack = 1'b1;  // same-cycle ack must be ignored
      step();
      exc_ack = 1'b0;
      chk("trap_mem_valid", 64'(mem_valid), 64'd0);
      chk("trap_mem_regwrite", 64'(mem_regwrite), 64'd0);
      chk("trap_mem_aluout", 64'(mem_aluout), 64'h7FFF_FFF0);
      chk("trap_mem_overflow", 64'(mem_overflow), 64'd1);
      chk("trap_exc_req", 64'(exc_req), 64'd1);
      chk("trap_flush", 64'(flush), 64'd1);
      chk("trap_epc", 64'(epc), 64'h0040_0010);
      chk("trap_cause", 64'(cause), 64'd12);
      chk("trap_ovf_count", 64'(ovf_count), 64'd1);

      ex_overflow = 1'b0; ex_trap_en = 1'b0; ex_pc = 32'h0000_0400; mem_stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_exc_req", 64'({exc_req, flush}), 64'b11);
         chk("hold_epc", 64'(epc), 64'h0040_0010);
         chk("hold_ovf_count", 64'(ovf_count), 64'd1);
         chk("hold_mem_valid", 64'({mem_valid, mem_regwrite}), 64'd0);
      end
      mem_stall = 1'b0;

      exc_ack = 1'b1;
      step();
      exc_ack = 1'b0;
      chk("ack_exc_req", 64'({exc_req, flush}), 64'd0);
      chk("ack_epc_cause", 64'({epc, cause}), {27'd0, 32'h0040_0010, 5'd12});

      ex_valid = 1'b1; ex_aluout = 32'h0000_1234; ex_rd = 5'd3; ex_regwrite = 1'b1;
      step();
      chk("drain_mem_valid", 64'({mem_valid, mem_regwrite}), 64'd0);
      step();
      chk("resume_mem_valid", 64'(mem_valid), 64'd1);
      chk("resume_mem_aluout", 64'(mem_aluout), 64'h1234);
      chk("resume_mem_rd", 64'(mem_rd), 64'd3);

      // 4. unsigned overflow passes through
      ex_overflow = 1'b1; ex_trap_en = 1'b0; ex_aluout = 32'h8000_0000; ex_memwrite = 1'b1;
      step();
      chk("uovf_mem_valid", 64'(mem_valid), 64'd1);
      chk("uovf_mem_overflow", 64'(mem_overflow), 64'd1);
      chk("uovf_enables", 64'({mem_regwrite, mem_memwrite}), 64'b11);
      chk("uovf_mem_aluout", 64'(mem_aluout), 64'h8000_0000);
      chk("uovf_exc_req", 64'(exc_req), 64'd0);
      chk("uovf_ovf_count", 64'(ovf_count), 64'd1);

      // 5. stall interaction
      ex_overflow = 1'b0; ex_memwrite = 1'b0; ex_aluout = 32'd7;
      step();
      chk("stall_cap", 64'(mem_aluout), 64'd7);
      mem_stall = 1'b1;
      ex_overflow = 1'b1; ex_trap_en = 1'b1; ex_aluout = 32'd99; ex_pc = 32'h0000_0100;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_aluout", 64'(mem_aluout), 64'd7);
         chk("stall_exc_req", 64'(exc_req), 64'd0);
         chk("stall_mem_valid", 64'(mem_valid), 64'd1);
      end
      mem_stall = 1'b0;
      step();
      chk("unstall_exc_req", 64'(exc_req), 64'd1);
      chk("unstall_epc", 64'(epc), 64'h0000_0100);
      chk("unstall_ovf_count", 64'(ovf_count), 64'd2);
      chk("unstall_sat_count", 64'(s_ovf_count), 64'd2);

      // 6. asynchronous reset mid-TRAP
      clear_ex();
      reset = 1'b0;
      #1;
      chk("arst_exc", 64'({exc_req, flush}), 64'd0);
      chk("arst_epc", 64'(epc), 64'd0);
      chk("arst_ovf_count", 64'(ovf_count), 64'd0);
      #2;
      reset = 1'b1;
      step();
      chk("arst_run_exc", 64'(exc_req), 64'd0);
      chk("arst_run_valid", 64'(mem_valid), 64'd0);

      for (int i = 0; i < 5; i++) begin
         ex_valid = 1'b1; ex_overflow = 1'b1; ex_trap_en = 1'b1;
         ex_pc = 32'h0000_1000 + 32'(i * 4);
         step();
         chk("sat_trap_req", 64'(exc_req), 64'd1);
         clear_ex();
         exc_ack = 1'b1;
         step();
         exc_ack = 1'b0;
         step();
      end
      chk("sat_count_wide", 64'(ovf_count), 64'd5);
      chk("sat_count_2b", 64'(s_ovf_count), 64'd3);
      chk("sat_epc", 64'(epc), 64'h0000_1010);

      // ex_valid=0 with overflow never traps
      ex_valid = 1'b0; ex_overflow = 1'b1; ex_trap_en = 1'b1;
      step();
      chk("inv_ovf_exc_req", 64'(exc_req), 64'd0);
      chk("inv_ovf_valid", 64'(mem_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_mem_ovf_stage.md
Name: ex_mem_ovf_stage

Overview:
Pipeline register between the execute-stage ALU and the memory stage. It captures the ALU result and overflow flag together with the instruction's control bits. It converts a trapping arithmetic overflow (signed add, sub, mul) into a precise exception: it squashes the faulting instruction's side effects, records EPC and cause, and holds a flush/exception request until the control unit acknowledges it. Unsigned-variant overflows pass through without trapping.

Parameters:
WIDTH, 32, datapath width of ALU result, store data and PC
CAUSE_OVF, 5'd12, cause code reported for arithmetic overflow
CNT_W, 16, width of the saturating overflow-trap counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
ex_valid  in  1  EX stage holds a real instruction this cycle
ex_aluout  in  WIDTH  ALU result
ex_overflow  in  1  ALU overflow flag
ex_trap_en  in  1  instruction traps on overflow (0 for unsigned variants)
ex_pc  in  WIDTH  PC of the EX instruction
ex_rd  in  5  destination register
ex_regwrite  in  1  instruction writes the register file
ex_memread  in  1  load
ex_memwrite  in  1  store
ex_wdata  in  WIDTH  store data
mem_stall  in  1  memory stage cannot accept; hold all registers
exc_ack  in  1  control unit has taken the exception
mem_valid  out  1  registered valid
mem_aluout  out  WIDTH  registered ALU result
mem_overflow  out  1  registered raw overflow flag (informational)
mem_rd  out  5  registered destination
mem_regwrite, mem_memread, mem_memwrite  out  1 each  registered controls
mem_wdata  out  WIDTH  registered store data
flush  out  1  kill IF/ID/EX contents; high whenever state is TRAP
exc_req  out  1  exception pending
epc  out  WIDTH  PC of the faulting instruction
cause  out  5  exception cause
ovf_count  out  CNT_W  number of overflow traps taken, saturating

Behaviour:
- Reset (reset=0, asynchronous): every output is 0. State is RUN.
- State machine:
  - RUN: normal operation.
  - TRAP: exception pending.
  - DRAIN: one cycle that discards the in-flight EX slot.
- RUN, mem_stall=1: all mem_* outputs hold their values. EX inputs are not sampled, so an overflow present during a stall is not acted on.
- RUN, mem_stall=0: define trap = ex_valid & ex_overflow & ex_trap_en.
  - trap=0: mem_* <= ex_*, and mem_valid <= ex_valid. Latency is 1 cycle.
  - trap=1: the instruction is squashed.
    - mem_valid, mem_regwrite, mem_memread and mem_memwrite become 0.
    - mem_aluout, mem_rd, mem_wdata and mem_overflow are still captured, for debug.
    - epc <= ex_pc; cause <= CAUSE_OVF.
    - ovf_count increments unless it is all-ones.
    - Next state is TRAP.
- TRAP:
  - exc_req=1 and flush=1.
  - mem_valid and all write/read enables are 0. mem_stall is ignored.
  - EX inputs are ignored.
  - epc and cause hold.
  - exc_ack is sampled only in TRAP. When exc_ack=1: exc_req and flush drop on the next edge, and next state is DRAIN.
  - An ack arriving in the same cycle the trap is detected (still in RUN) is ignored.
- DRAIN:
  - Enables and mem_valid are forced to 0 for one cycle; EX inputs are ignored.
  - Next state is RUN unconditionally.
  - epc and cause keep their last values until the next trap.
- exc_req and flush are registered state decodes, glitch-free.
- An overflow with ex_trap_en=0 is a plain pass-through: mem_overflow=1, all enables are preserved, no trap.
- Reset asserted in any state (including mid-TRAP) returns to RUN with all outputs 0. This includes ovf_count and epc.
- ex_valid=0 with ex_overflow=1 never traps, and produces mem_valid=0.

Test Plan:
1. Reset: hold reset=0 with random inputs -> all outputs 0. Release, ex_valid=0 -> mem_valid stays 0, flush=0.
2. Pass-through: ex_valid=1, ex_aluout=32'h0000_0005, ex_rd=8, ex_regwrite=1, overflow=0 -> next cycle mem_valid=1, mem_aluout=5, mem_rd=8, mem_regwrite=1, exc_req=0.
3. Signed trap: ex_valid=1, ex_overflow=1, ex_trap_en=1, ex_pc=32'h0040_0010, ex_regwrite=1.
   - Next cycle: mem_valid=0, mem_regwrite=0, exc_req=1, flush=1, epc=32'h0040_0010, cause=12, ovf_count=1.
   - Hold exc_ack=0 for 4 cycles -> all unchanged.
   - Pulse exc_ack -> next cycle exc_req=0 (DRAIN); the following cycle accepts a new instruction.
4. Unsigned overflow: ex_valid=1, ex_overflow=1, ex_trap_en=0, ex_aluout=32'h8000_0000, ex_regwrite=1 -> mem_valid=1, mem_overflow=1, mem_regwrite=1, exc_req=0, ovf_count unchanged.
5. Stall interaction:
   - Capture aluout=7, then mem_stall=1 for 3 cycles while EX presents a trapping overflow -> mem_aluout stays 7, no exc_req.
   - Drop the stall with the trap still present -> exc_req=1 next cycle.
6. Reset mid-TRAP, then saturation:
   - In TRAP, pulse reset=0 -> exc_req=0, flush=0, epc=0, ovf_count=0 immediately; after release the block is in RUN.
   - With CNT_W=2, take 5 traps -> ovf_count=3.
